hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard controller for the 5-stage MIPS core. It generates pipeline-register write enables and flushes for load-use interlocks, taken-branch and jump squashes, and data-memory wait stalls. It also sequences the multi-cycle multiply/divide unit through a RUN/MULDIV state machine. The forwarding unit resolves ALU-to-ALU dependencies; this block covers only the hazards that forwarding cannot.

## Interface
Parameters:
- MUL_CYCLES, 4: multiply latency in cycles, ≥1
- DIV_CYCLES, 32: divide latency in cycles, ≥ MUL_CYCLES
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before the error flag is set

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- MemRead_EX  in  1  EX instruction is a load
- wrReg_EX  in  5  destination register of EX instruction
- RS_ID, RT_ID  in  5  source registers of ID instruction
- UsesRT_ID  in  1  ID instruction reads RT
- MulDiv_ID  in  1  ID instruction is mult/multu/div/divu
- Div_ID  in  1  qualifies MulDiv_ID as divide
- MfHiLo_ID  in  1  ID instruction reads HI/LO
- Jump_ID  in  1  unconditional jump decoded in ID
- Branch_taken_EX  in  1  branch in EX resolved taken
- MemAccess_MEM  in  1  MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1  pipeline-register enables
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1  insert bubble into register
- MulDiv_start  out  1  registered one-cycle start pulse to the mul/div unit
- MulDiv_busy  out  1  high while state = MULDIV
- mem_timeout  out  1  sticky error flag
- stall_count  out  16  saturating count of cycles with PCWrite = 0

## Operation
Condition terms:
- memstall = MemAccess_MEM & !dmem_ready
- loaduse = MemRead_EX & (wrReg_EX != 0) & ((wrReg_EX == RS_ID) | (UsesRT_ID & wrReg_EX == RT_ID))
- mdhaz = (state == MULDIV) & (MfHiLo_ID | MulDiv_ID)

Output priority, highest first. Defaults are all enables 1 and all flushes 0.
1. memstall: PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0; MEM_WB_Flush = 1. Branch_taken_EX and Jump_ID are ignored, so a frozen branch is honoured once the stall releases.
2. Branch_taken_EX: IF_ID_Flush = 1 and ID_EX_Flush = 1. PCWrite stays 1 so the PC redirects.
3. loaduse or mdhaz: PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1.
4. Jump_ID: IF_ID_Flush = 1.

Mul/div acceptance:
- Acceptance occurs when state == RUN, MulDiv_ID = 1, ID_EX_Write = 1, and neither ID_EX_Flush nor IF_ID_Flush is asserted.
- On the next edge: state → MULDIV, MulDiv_start ← 1, and counter ← (Div_ID ? DIV_CYCLES : MUL_CYCLES) − 1.
- The counter is ceil(log2(DIV_CYCLES))+1 bits wide.

State machine:
- RUN → MULDIV on acceptance.
- In MULDIV the counter decrements every cycle, including during memstall. The mul/div unit is free-running.
- When counter == 0, MULDIV → RUN on the next edge.
- MulDiv_start is high only in the first MULDIV cycle.
- A MulDiv_ID seen in MULDIV is stalled (mdhaz) and accepted in the first RUN cycle.

Memory timeout:
- A wait counter increments each memstall cycle and clears on any cycle without memstall.
- Reaching MEM_TIMEOUT sets mem_timeout. The flag stays set until reset.

stall_count increments each cycle PCWrite = 0 and saturates at 0xFFFF.

## Timing
- Reset (rst_n low, asynchronous):
  - Registered state: state = RUN, counter = 0, MulDiv_start = 0, MulDiv_busy = 0, mem_timeout = 0, stall_count = 0, wait counter = 0.
  - Forced outputs while low: all four enables 0, IF_ID_Flush = 1, ID_EX_Flush = 1, MEM_WB_Flush = 1.
- Reset mid-MULDIV aborts the sequence immediately. No MulDiv_start is issued after release.
- Enables and flushes are combinational from inputs and current state, valid in the same cycle.
- Mul/div accepted at cycle t: MulDiv_start is high at t+1 and MulDiv_busy is high for cycles t+1 through t+N (N = MUL_CYCLES or DIV_CYCLES). MfHiLo_ID is released at t+N+1.
- Load-use costs exactly one bubble. In the following cycle the load is in MEM, so loaduse is false.
- When Branch_taken_EX and loaduse coincide, only the flush is applied and no stall occurs.

## Test plan
- Load-use: MemRead_EX = 1, wrReg_EX = 8, RS_ID = 8 → one cycle of PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1; normal the next cycle; stall_count = 1. Repeat with wrReg_EX = 0 → no stall.
- Multiply then mfhi: MulDiv_ID = 1, Div_ID = 0 accepted at t; MfHiLo_ID held from t+1 → MulDiv_start at t+1 only, busy t+1..t+4, stall t+1..t+4, release at t+5.
- Divide with memory stall: DIV_CYCLES = 32 accepted, with memstall for 5 cycles inside → busy still drops after exactly 32 cycles; all four enables 0 and MEM_WB_Flush = 1 during the 5 stall cycles.
- Branch over load-use and mul/div: Branch_taken_EX = 1 together with loaduse and MulDiv_ID = 1 → IF_ID_Flush = ID_EX_Flush = 1, PCWrite = 1, no MULDIV entry.
- Timeout: dmem_ready held 0 with MemAccess_MEM = 1 for 255 cycles → mem_timeout = 1 and stays 1 after dmem_ready returns; stall_count = 255.
- Async reset mid-divide at counter = 10 → busy = 0 and state = RUN immediately; after release, MulDiv_ID = 0 → no MulDiv_start.

Source files
------------

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline hazard control for the 5-stage MIPS core. Produces the
//   pipeline-register write enables and bubble/flush controls for hazards
//   that forwarding cannot resolve: data-memory wait stalls, taken-branch
//   and jump squashes, load-use interlocks and HI/LO / mul-div structural
//   hazards. It also sequences the multi-cycle mul/div unit.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RUN    | no mul/div in flight; a mul/div in ID may be accepted
//   MULDIV | mul/div unit busy; HI/LO readers and new mul/div are stalled
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   MemRead_EX, wrReg_EX           load in EX and its destination
//   RS_ID, RT_ID, UsesRT_ID        ID-stage source operands
//   MulDiv_ID, Div_ID, MfHiLo_ID   ID-stage mul/div and HI/LO reader
//   Jump_ID, Branch_taken_EX       control-flow redirects
//   MemAccess_MEM, dmem_ready      data-memory handshake
//   PCWrite .. EX_MEM_Write        pipeline-register enables
//   IF_ID_Flush .. MEM_WB_Flush    bubble insertion
//   MulDiv_start, MulDiv_busy      mul/div unit sequencing
//   mem_timeout                    sticky data-memory timeout flag
//   stall_count                    saturating count of PC-frozen cycles
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_EX,
  input  logic [4:0]  wrReg_EX,
  input  logic [4:0]  RS_ID,
  input  logic [4:0]  RT_ID,
  input  logic        UsesRT_ID,
  input  logic        MulDiv_ID,
  input  logic        Div_ID,
  input  logic        MfHiLo_ID,
  input  logic        Jump_ID,
  input  logic        Branch_taken_EX,
  input  logic        MemAccess_MEM,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MEM_WB_Flush,
  output logic        MulDiv_start,
  output logic        MulDiv_busy,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            start_q;
  logic            busy_q;
  logic [WW-1:0]   wait_q, wait_d;
  logic            timeout_q, timeout_d;
  logic [15:0]     stall_q, stall_d;

  logic memstall, loaduse, mdhaz, accept;

  assign memstall = MemAccess_MEM & ~dmem_ready;
  assign loaduse  = MemRead_EX & (wrReg_EX != 5'd0) &
                    ((wrReg_EX == RS_ID) | (UsesRT_ID & (wrReg_EX == RT_ID)));
  assign mdhaz    = (state_q == MULDIV) & (MfHiLo_ID | MulDiv_ID);

  // Priority chain; reset forces a full bubble regardless of inputs.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (memstall) begin
      // Branch/jump are held in their frozen registers and honoured later.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (Branch_taken_EX) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (loaduse || mdhaz) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end else if (Jump_ID) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  assign accept = (state_q == RUN) & MulDiv_ID & ID_EX_Write &
                  ~ID_EX_Flush & ~IF_ID_Flush;

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (memstall) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end
    if (wait_d == WAIT_MAX) begin
      timeout_d = 1'b1;
    end
    stall_d = stall_q;
    if (!PCWrite && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Mul/div sequencer plus event counters. The mul/div counter keeps
  // running through memory stalls because the unit itself never freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      start_q   <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept) begin
            state_q <= MULDIV;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            cnt_q   <= Div_ID ? DIV_LOAD : MUL_LOAD;
          end
        end
        MULDIV: begin
          if (cnt_q == '0) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MulDiv_start = start_q;
  assign MulDiv_busy  = busy_q;
  assign mem_timeout  = timeout_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int MULC = 4;
  localparam int DIVC = 32;
  localparam int MTO  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead_EX, UsesRT_ID, MulDiv_ID, Div_ID, MfHiLo_ID;
  logic        Jump_ID, Branch_taken_EX, MemAccess_MEM, dmem_ready;
  logic [4:0]  wrReg_EX, RS_ID, RT_ID;
  logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic        IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush;
  logic        MulDiv_start, MulDiv_busy, mem_timeout;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining busy cycles, start pulse, wait run
  // length, sticky timeout, stall count.
  int md_left, m_wait, m_stall;
  bit m_start, m_to;
  // Expected combinational outputs for the current cycle.
  bit e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_wbf;

  hazard_controller #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .MEM_TIMEOUT(MTO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_EX(MemRead_EX), .wrReg_EX(wrReg_EX), .RS_ID(RS_ID), .RT_ID(RT_ID),
    .UsesRT_ID(UsesRT_ID), .MulDiv_ID(MulDiv_ID), .Div_ID(Div_ID),
    .MfHiLo_ID(MfHiLo_ID), .Jump_ID(Jump_ID), .Branch_taken_EX(Branch_taken_EX),
    .MemAccess_MEM(MemAccess_MEM), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MEM_WB_Flush(MEM_WB_Flush), .MulDiv_start(MulDiv_start), .MulDiv_busy(MulDiv_busy),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemRead_EX = 0; wrReg_EX = 0; RS_ID = 0; RT_ID = 0; UsesRT_ID = 0;
    MulDiv_ID = 0; Div_ID = 0; MfHiLo_ID = 0; Jump_ID = 0;
    Branch_taken_EX = 0; MemAccess_MEM = 0; dmem_ready = 1;
  endtask

  // Expected outputs derived from the hazard rules, highest priority first.
  task automatic predict();
    bit ms, lu, busy;
    ms   = MemAccess_MEM && !dmem_ready;
    lu   = MemRead_EX && wrReg_EX != 0 &&
           (wrReg_EX == RS_ID || (UsesRT_ID && wrReg_EX == RT_ID));
    busy = md_left > 0;
    {e_pc, e_ifw, e_idw, e_exw} = 4'b1111;
    {e_iff, e_idf, e_wbf} = 3'b000;
    if (ms) begin
      {e_pc, e_ifw, e_idw, e_exw} = 4'b0000; e_wbf = 1;
    end else if (Branch_taken_EX) begin
      e_iff = 1; e_idf = 1;
    end else if (lu || (busy && (MfHiLo_ID || MulDiv_ID))) begin
      e_pc = 0; e_ifw = 0; e_idf = 1;
    end else if (Jump_ID) begin
      e_iff = 1;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":start"}, MulDiv_start, m_start);
    chk({tag, ":busy"}, MulDiv_busy, md_left > 0);
    chk({tag, ":timeout"}, mem_timeout, m_to);
    chk({tag, ":stall_count"}, stall_count, m_stall);
  endtask

  // One clock cycle: check same-cycle outputs, clock, advance model, check registers.
  task automatic tick(input string tag);
    bit acc, ms;
    #1;
    predict();
    chk({tag, ":enables"}, {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write},
        {e_pc, e_ifw, e_idw, e_exw});
    chk({tag, ":flushes"}, {IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}, {e_iff, e_idf, e_wbf});
    acc = md_left == 0 && MulDiv_ID && e_idw && !e_idf && !e_iff;
    ms  = MemAccess_MEM && !dmem_ready;
    @(posedge clk);
    m_start = acc;
    if (acc) md_left = Div_ID ? DIVC : MULC;
    else if (md_left > 0) md_left--;
    m_wait = ms ? m_wait + 1 : 0;
    if (m_wait >= MTO) m_to = 1;
    if (!e_pc && m_stall < 65535) m_stall++;
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    md_left = 0; m_wait = 0; m_stall = 0; m_start = 0; m_to = 0;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    #1;
    model_reset();
    chk({tag, ":rst_enables"}, {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write}, 4'b0000);
    chk({tag, ":rst_flushes"}, {IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}, 3'b111);
    check_regs({tag, ":rst"});
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    apply_reset("reset");

    // Load-use: one bubble, then normal; r0 destination never stalls.
    MemRead_EX = 1; wrReg_EX = 8; RS_ID = 8;
    tick("loaduse");
    idle();
    tick("loaduse_next");
    chk("loaduse_count", stall_count, 1);
    MemRead_EX = 1; wrReg_EX = 0; RS_ID = 0;
    tick("loaduse_r0");
    MemRead_EX = 1; wrReg_EX = 9; RT_ID = 9; UsesRT_ID = 1; RS_ID = 3;
    tick("loaduse_rt");
    idle();

    // Multiply then mfhi held: stall while busy, released at t+5.
    MulDiv_ID = 1;
    tick("mul_accept");
    chk("mul_start_t1", MulDiv_start, 1);
    MulDiv_ID = 0; MfHiLo_ID = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("mul_busy_window", MulDiv_busy, 1);
      tick("mul_mfhi");
    end
    chk("mul_busy_done", MulDiv_busy, 0);
    tick("mfhi_release");
    idle();

    // Divide with a 5-cycle memory stall inside; busy length is unchanged.
    MulDiv_ID = 1; Div_ID = 1;
    tick("div_accept");
    idle();
    for (int i = 1; i <= DIVC; i++) begin
      if (i >= 10 && i < 15) begin MemAccess_MEM = 1; dmem_ready = 0; end
      else begin MemAccess_MEM = 0; dmem_ready = 1; end
      if (i == DIVC) chk("div_busy_last", MulDiv_busy, 1);
      tick("div_run");
    end
    chk("div_busy_done", MulDiv_busy, 0);
    idle();

    // Branch beats load-use and mul/div acceptance.
    Branch_taken_EX = 1; MemRead_EX = 1; wrReg_EX = 5; RS_ID = 5; MulDiv_ID = 1;
    tick("branch_over");
    chk("branch_no_muldiv", MulDiv_busy, 0);
    idle();
    Jump_ID = 1; MulDiv_ID = 1;
    tick("jump_blocks_md");
    idle();

    // Memory timeout after MTO consecutive wait cycles; sticky afterwards.
    apply_reset("reset2");
    MemAccess_MEM = 1; dmem_ready = 0;
    for (int i = 0; i < MTO; i++) tick("timeout_wait");
    chk("timeout_set", mem_timeout, 1);
    chk("timeout_stall_count", stall_count, MTO);
    dmem_ready = 1;
    tick("timeout_sticky1");
    idle();
    tick("timeout_sticky2");
    chk("timeout_stays", mem_timeout, 1);

    // Async reset in the middle of a divide.
    MulDiv_ID = 1; Div_ID = 1;
    tick("div2_accept");
    idle();
    for (int i = 0; i < 21; i++) tick("div2_run");
    #2;
    apply_reset("reset_mid_div");
    chk("reset_mid_busy", MulDiv_busy, 0);
    tick("post_reset1");
    tick("post_reset2");
    chk("post_reset_no_start", MulDiv_start, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      MemRead_EX      = ($urandom_range(0, 9) < 3);
      wrReg_EX        = 5'($urandom_range(0, 5));
      RS_ID           = 5'($urandom_range(0, 5));
      RT_ID           = 5'($urandom_range(0, 5));
      UsesRT_ID       = 1'($urandom);
      MulDiv_ID       = ($urandom_range(0, 9) < 2);
      Div_ID          = 1'($urandom);
      MfHiLo_ID       = ($urandom_range(0, 9) < 2);
      Jump_ID         = ($urandom_range(0, 9) < 1);
      Branch_taken_EX = ($urandom_range(0, 9) < 1);
      MemAccess_MEM   = ($urandom_range(0, 9) < 3);
      dmem_ready      = 1'($urandom);
      tick("random");
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
